// File: rtl/mdu_seq.sv
// mdu_seq: iterative RV64M multiply/divide sequencer for the execute stage.
// It runs a radix-2 shift-add multiplier or a restoring divider, one step per
// clock, for 64 iterations or 32 for word ops. Divide-by-zero and signed
// overflow finish on the accept edge.
// Optional feature macro: MDU_EARLY_OUT_EN. When it is defined, a multiply by
// zero and a divide whose divisor magnitude exceeds the dividend magnitude
// also finish on the accept edge.
module mdu_seq #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 7
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush_i,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [2:0]      op_i,
   input  logic            word_i,
   input  logic [XLEN-1:0] op1_i,
   input  logic [XLEN-1:0] op2_i,
   output logic            valid_o,
   input  logic            ready_i,
   output logic [XLEN-1:0] result_o,
   output logic            busy_o
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t state, state_next;

   logic [2:0]        op_q;
   logic              word_q;
   logic              s1_q;
   logic              s2_q;
   logic [XLEN-1:0]   b_q;
   logic [2*XLEN-1:0] acc_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [XLEN-1:0]   result_q;

   logic            is_div_in;
   logic            is_rem_in;
   logic            sign1_in;
   logic            sign2_in;
   logic            word_in;
   logic [XLEN-1:0] ext1;
   logic [XLEN-1:0] ext2;
   logic            neg1;
   logic            neg2;
   logic [XLEN-1:0] mag1;
   logic [XLEN-1:0] mag2;
   logic [XLEN-1:0] min_val;
   logic            div_zero;
   logic            div_ovf;
   logic            special;
   logic [XLEN-1:0] special_res;

   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next;
   logic [XLEN:0]     rem_sh;
   logic [XLEN:0]     div_diff;
   logic [2*XLEN-1:0] div_next;

   logic [2*XLEN-1:0] prod;
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   quo_s;
   logic [XLEN-1:0]   rem_s;
   logic [XLEN-1:0]   sel;
   logic [XLEN-1:0]   fix_res;

   // Sign-extends a 32-bit value to the full datapath width.
   function automatic logic [XLEN-1:0] word_sext(input logic [31:0] x);
      return {{(XLEN-32){x[31]}}, x};
   endfunction

   // Request decode: operand signedness, effective word flag, extension,
   // magnitudes and the RISC-V divide corner cases.
   assign is_div_in = op_i[2];
   assign is_rem_in = op_i[1];
   assign sign1_in  = op_i[2] ? ~op_i[0] : (op_i[1:0] != 2'b11);
   assign sign2_in  = op_i[2] ? ~op_i[0] : (op_i[1:0] <= 2'b01);
   assign word_in   = word_i & (op_i[2] | (op_i[1:0] == 2'b00));

   assign ext1 = !word_in ? op1_i :
                 sign1_in ? word_sext(op1_i[31:0]) : {{(XLEN-32){1'b0}}, op1_i[31:0]};
   assign ext2 = !word_in ? op2_i :
                 sign2_in ? word_sext(op2_i[31:0]) : {{(XLEN-32){1'b0}}, op2_i[31:0]};

   assign neg1 = sign1_in & ext1[XLEN-1];
   assign neg2 = sign2_in & ext2[XLEN-1];
   assign mag1 = neg1 ? -ext1 : ext1;
   assign mag2 = neg2 ? -ext2 : ext2;

   assign min_val  = word_in ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
   assign div_zero = is_div_in & (ext2 == '0);
   assign div_ovf  = is_div_in & sign1_in & (ext1 == min_val) & (ext2 == '1);

   // Picks the requests that finish on the accept edge and their final result.
   always_comb begin
      special     = 1'b0;
      special_res = '0;
      if (div_zero) begin
         special     = 1'b1;
         special_res = is_rem_in ? (word_in ? word_sext(ext1[31:0]) : ext1) : '1;
      end else if (div_ovf) begin
         special     = 1'b1;
         special_res = is_rem_in ? '0 : ext1;
      end
`ifdef MDU_EARLY_OUT_EN
      else if (!is_div_in && ((ext1 == '0) || (ext2 == '0))) begin
         special     = 1'b1;
         special_res = '0;
      end else if (is_div_in && (mag2 > mag1)) begin
         special     = 1'b1;
         special_res = is_rem_in ? (word_in ? word_sext(ext1[31:0]) : ext1) : '0;
      end
`endif
   end

   // One iteration step: add-and-shift-right for multiply; shift-left and
   // trial-subtract for divide. acc_q holds {high, low}, b_q the second operand.
   assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
   assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
   assign rem_sh   = acc_q[2*XLEN-1:XLEN-1];
   assign div_diff = rem_sh - {1'b0, b_q};
   assign div_next = div_diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

   // Final sign fix-up and selection of the architectural result. Word
   // multiplies ran only 32 steps, so their product still sits 32 bits up.
   assign prod   = word_q ? (acc_q >> 32) : acc_q;
   assign prod_s = (s1_q ^ s2_q) ? -prod : prod;
   assign quo_s  = (s1_q ^ s2_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
   assign rem_s  = s1_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

   // Chooses low/high product half, quotient or remainder for the latched op.
   always_comb begin
      sel = '0;
      if (op_q[2])
         sel = op_q[1] ? rem_s : quo_s;
      else if (op_q[1:0] == 2'b00)
         sel = prod_s[XLEN-1:0];
      else
         sel = prod_s[2*XLEN-1:XLEN];
   end

   assign fix_res = word_q ? word_sext(sel[31:0]) : sel;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state logic; flush overrides every transition.
   always_comb begin
      state_next = state;
      if (flush_i) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: if (valid_i) state_next = special ? DONE : CALC;
            CALC: if (cnt_q <= CNT_W'(1)) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: if (ready_i) state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // Datapath registers: capture on accept, iterate in CALC, latch in FIX.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q     <= '0;
         word_q   <= 1'b0;
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         b_q      <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else if (!flush_i) begin
         case (state)
            IDLE: begin
               if (valid_i) begin
                  op_q   <= op_i;
                  word_q <= word_in;
                  s1_q   <= neg1;
                  s2_q   <= neg2;
                  b_q    <= mag2;
                  acc_q  <= {{XLEN{1'b0}}, (word_in && is_div_in) ? (mag1 << 32) : mag1};
                  cnt_q  <= word_in ? CNT_W'(32) : CNT_W'(XLEN);
                  if (special)
                     result_q <= special_res;
               end
            end
            CALC: begin
               acc_q <= op_q[2] ? div_next : mul_next;
               cnt_q <= cnt_q - CNT_W'(1);
            end
            FIX: result_q <= fix_res;
            default: ;
         endcase
      end
   end

   assign ready_o  = (state == IDLE);
   assign valid_o  = (state == DONE);
   assign busy_o   = (state != IDLE);
   assign result_o = result_q;

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed self-checking bench for mdu_seq.
// Each step drives one request, measures edges from accept to valid_o,
// and compares latency, result and handshake against hand-computed values.
module tb_mdu_seq;

   localparam int XLEN = 64;

`ifdef MDU_EARLY_OUT_EN
   localparam int EARLY_LAT = 0;
`else
   localparam int EARLY_LAT = 65;
`endif

   logic            clk;
   logic            rst;
   logic            flush_i;
   logic            valid_i;
   logic            ready_o;
   logic [2:0]      op_i;
   logic            word_i;
   logic [XLEN-1:0] op1_i;
   logic [XLEN-1:0] op2_i;
   logic            valid_o;
   logic            ready_i;
   logic [XLEN-1:0] result_o;
   logic            busy_o;

   int n_compared;
   int n_mismatched;

   mdu_seq #(.XLEN(XLEN), .CNT_W(7)) dut (
      .clk      (clk),
      .rst      (rst),
      .flush_i  (flush_i),
      .valid_i  (valid_i),
      .ready_o  (ready_o),
      .op_i     (op_i),
      .word_i   (word_i),
      .op1_i    (op1_i),
      .op2_i    (op2_i),
      .valid_o  (valid_o),
      .ready_i  (ready_i),
      .result_o (result_o),
      .busy_o   (busy_o)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compares one observed value against its expected value.
   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_compared++;
      assert (obs === exp) else begin
         n_mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drives one request for a single cycle, then scrambles the operands.
   task automatic apply_stimulus(input logic [2:0] op, input logic word,
                                 input logic [63:0] a, input logic [63:0] b);
      @(negedge clk);
      op_i    = op;
      word_i  = word;
      op1_i   = a;
      op2_i   = b;
      valid_i = 1'b1;
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      op1_i   = {$urandom, $urandom};
      op2_i   = {$urandom, $urandom};
   endtask

   // Full transaction: accept, latency, result, optional backpressure, release.
   task automatic run_op(input string tag, input logic [2:0] op, input logic word,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp_res, input int exp_lat, input int hold);
      int lat;
      apply_stimulus(op, word, a, b);
      lat = 0;
      while (!valid_o && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check_output({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check_output({tag, "_res"}, result_o, exp_res);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check_output({tag, "_hold_res"}, result_o, exp_res);
         check_output({tag, "_hold_flags"}, {61'b0, valid_o, ready_o, busy_o}, 64'b101);
      end
      @(negedge clk);
      ready_i = 1'b1;
      @(posedge clk);
      #1;
      ready_i = 1'b0;
      check_output({tag, "_release"}, {61'b0, valid_o, ready_o, busy_o}, 64'b010);
   endtask

   // Directed sequence of steps.
   initial begin
      logic seen_valid;
      n_compared   = 0;
      n_mismatched = 0;
      rst     = 1'b1;
      flush_i = 1'b0;
      valid_i = 1'b0;
      ready_i = 1'b0;
      op_i    = 3'b000;
      word_i  = 1'b0;
      op1_i   = '0;
      op2_i   = '0;

      repeat (3) @(posedge clk);
      #1;
      check_output("reset_flags", {61'b0, valid_o, ready_o, busy_o}, 64'b010);
      check_output("reset_res", result_o, 64'h0);
      @(negedge clk);
      rst = 1'b0;

      run_op("mul",    3'b000, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 65, 0);
      run_op("mulhu",  3'b011, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65, 0);
      run_op("mulh",   3'b001, 1'b0, '1, '1, 64'h0, 65, 0);
      run_op("mulhsu", 3'b010, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
      run_op("mulw",   3'b000, 1'b1, 64'h1_0000_0003, 64'd5, 64'd15, 33, 0);
      run_op("divu0",  3'b101, 1'b0, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
      run_op("rem0",   3'b110, 1'b0, 64'd7, 64'd0, 64'd7, 0, 0);
      run_op("divovf", 3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 0, 0);
      run_op("removf", 3'b110, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h0, 0, 0);
      run_op("divw",   3'b100, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33, 0);
      run_op("remw",   3'b110, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33, 0);
      run_op("divu",   3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 65, 0);
      run_op("divusm", 3'b101, 1'b0, 64'd5, 64'd9, 64'd0, EARLY_LAT, 0);
      run_op("bp_rem", 3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65, 10);

      $display("[TB] flush mid-divide");
      apply_stimulus(3'b100, 1'b0, 64'd1000, 64'd3);
      repeat (19) @(posedge clk);
      @(negedge clk);
      flush_i = 1'b1;
      @(posedge clk);
      #1;
      flush_i = 1'b0;
      check_output("flush_flags", {61'b0, valid_o, ready_o, busy_o}, 64'b010);
      check_output("flush_res", result_o, 64'hFFFF_FFFF_FFFF_FFFE);
      seen_valid = 1'b0;
      repeat (80) begin
         @(posedge clk);
         #1;
         seen_valid = seen_valid | valid_o;
      end
      check_output("flush_no_valid", {63'b0, seen_valid}, 64'b0);

      @(negedge clk);
      op_i    = 3'b000;
      op1_i   = 64'd9;
      op2_i   = 64'd9;
      valid_i = 1'b1;
      flush_i = 1'b1;
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      flush_i = 1'b0;
      check_output("flush_drop", {61'b0, valid_o, ready_o, busy_o}, 64'b010);

      run_op("mul_after_flush", 3'b000, 1'b0, 64'd2, 64'd3, 64'd6, 65, 0);

      $display("[TB] reset mid-calc");
      apply_stimulus(3'b000, 1'b0, 64'd4, 64'd4);
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_output("rst_mid_flags", {61'b0, valid_o, ready_o, busy_o}, 64'b010);
      check_output("rst_mid_res", result_o, 64'h0);
      @(negedge clk);
      rst = 1'b0;

      run_op("divu0_after_rst", 3'b101, 1'b0, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
